load_memory_read_unit: RTL

LOAD_MEMORY_READ_UNIT -- requirements
Module: load_memory_read_unit

---
 rtl/load_memory_read_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/load_memory_read_unit.sv
// Load unit: turns a CPU load into an AXI-style read (AR then R) and returns
// the aligned, sign/zero-extended result with a one-cycle valid pulse.
module load_memory_read_unit (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        is_load,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    output logic [31:0] load_data_out,
    output logic        load_valid,
    output logic        load_error,
    output logic        stall,
    output logic [31:0] ARADDR,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RVALID,
    output logic        RREADY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] araddr_q, araddr_d;
    logic [31:0] data_q, data_d;
    logic        error_q, error_d;
    logic        accept;

    function automatic logic is_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b001, 3'b101: return off[0];
            3'b010:         return (off != 2'b00);
            default:        return 1'b0;
        endcase
    endfunction

    // Byte/half selection from the word lane, then sign or zero extension.
    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    assign accept = is_legal(funct3) && !is_misaligned(funct3, address[1:0]);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= S_IDLE;
            funct3_q <= 3'b000;
            offset_q <= 2'b00;
            araddr_q <= 32'h0;
            data_q   <= 32'h0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            offset_q <= offset_d;
            araddr_q <= araddr_d;
            data_q   <= data_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (is_load) state_d = accept ? S_AR : S_DONE;
            S_AR:    if (ARREADY) state_d = S_R;
            S_R:     if (RVALID)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Result registers change only on entry to DONE, so they hold in between.
    always_comb begin
        funct3_d = funct3_q;
        offset_d = offset_q;
        araddr_d = araddr_q;
        data_d   = data_q;
        error_d  = error_q;
        if (state_q == S_IDLE && is_load) begin
            funct3_d = funct3;
            offset_d = address[1:0];
            araddr_d = {address[31:2], 2'b00};
            if (!accept) begin
                data_d  = 32'h0;
                error_d = 1'b1;
            end
        end else if (state_q == S_R && RVALID) begin
            error_d = (RRESP != 2'b00);
            data_d  = (RRESP != 2'b00) ? 32'h0 : extract(funct3_q, offset_q, RDATA);
        end
    end

    always_comb begin
        ARVALID    = (state_q == S_AR);
        RREADY     = (state_q == S_R);
        load_valid = (state_q == S_DONE);
        stall      = (state_q == S_AR) || (state_q == S_R) ||
                     ((state_q == S_IDLE) && is_load);
    end

    assign ARADDR        = araddr_q;
    assign load_data_out = data_q;
    assign load_error    = error_q;

endmodule
